// File: rtl/rebel_logic_pkg.sv
// rebel_logic_pkg: opcode constants and the per-bit logic function shared by the logic lane
package rebel_logic_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'd0;
    localparam op_t OP_OR   = 3'd1;
    localparam op_t OP_XOR  = 3'd2;
    localparam op_t OP_XNOR = 3'd3;
    localparam op_t OP_NAND = 3'd4;
    localparam op_t OP_NOR  = 3'd5;
    localparam op_t OP_NOTA = 3'd6;
    localparam op_t OP_PASS = 3'd7;

    // Operates at the widest legal width; callers truncate to their own WIDTH.
    function automatic logic [63:0] logic_op(op_t op, logic [63:0] a, logic [63:0] b);
        case (op)
            OP_AND:  logic_op = a & b;
            OP_OR:   logic_op = a | b;
            OP_XOR:  logic_op = a ^ b;
            OP_XNOR: logic_op = ~(a ^ b);
            OP_NAND: logic_op = ~(a & b);
            OP_NOR:  logic_op = ~(a | b);
            OP_NOTA: logic_op = ~a;
            default: logic_op = a;
        endcase
    endfunction

endpackage

// File: rtl/rebel_popcount.sv
// rebel_popcount: combinational count of set bits in a WIDTH-bit word
module rebel_popcount #(
    parameter int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_ones
);

    // Sum every bit into the count
    always_comb begin
        o_ones = '0;
        for (int i = 0; i < WIDTH; i++) o_ones = o_ones + CNT_W'(i_data[i]);
    end

endmodule

// File: rtl/rebel_logic_pipe.sv
// rebel_logic_pipe: two-stage valid/ready bitwise logic lane with accumulate, zero flag and ones-count
module rebel_logic_pipe
    import rebel_logic_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_ones
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic [WIDTH-1:0] r_acc;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_result;
    logic             r_out_zero;
    logic [CNT_W-1:0] r_out_ones;

    logic             w_s2_en;
    logic             w_s1_en;
    logic             w_in_fire;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_op;
    logic [CNT_W-1:0] w_ones;

    assign w_s2_en   = !r_out_valid || out_ready;
    assign w_s1_en   = !r_s1_valid || w_s2_en;
    assign w_in_fire = in_valid && w_s1_en;
    assign w_b       = in_acc ? r_acc : in_b;
    assign w_op      = WIDTH'(logic_op(op_t'(in_op), 64'(in_a), 64'(w_b)));

    assign in_ready   = w_s1_en;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_zero   = r_out_zero;
    assign out_ones   = r_out_ones;

    rebel_popcount #(.WIDTH(WIDTH)) u_popcount (
        .i_data (r_s1_data),
        .o_ones (w_ones)
    );

    // Stage 1 and accumulator: capture the op result on every input transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_acc      <= '0;
        end else begin
            if (w_s1_en) r_s1_valid <= w_in_fire;
            if (w_in_fire) begin
                r_s1_data <= w_op;
                r_acc     <= w_op;
            end
        end
    end

    // Stage 2: register result, zero flag and ones-count; hold while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_zero   <= 1'b0;
            r_out_ones   <= '0;
        end else if (w_s2_en) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_result <= r_s1_data;
                r_out_zero   <= (r_s1_data == '0);
                r_out_ones   <= w_ones;
            end
        end
    end

endmodule

// File: tb/tb_rebel_logic_pipe.sv
// tb_rebel_logic_pipe: table vectors, directed pipeline corner cases and random traffic vs a queue model
module tb_rebel_logic_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_acc, out_valid, out_ready, out_zero;
    logic [2:0]  in_op;
    logic [15:0] in_a, in_b, out_result;
    logic [4:0]  out_ones;

    logic        w5_in_valid, w5_in_ready, w5_in_acc, w5_out_valid, w5_out_ready, w5_out_zero;
    logic [2:0]  w5_in_op;
    logic [4:0]  w5_in_a, w5_in_b, w5_out_result;
    logic [2:0]  w5_out_ones;

    int          total = 0;
    int          bad = 0;
    int          ncyc = 0;
    logic [15:0] macc = '0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          cyc_q[$];
    logic        held_v = 1'b0;
    logic [15:0] held_r = '0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        z;
        logic [4:0]  n;
    } vec_t;

    vec_t tv[8];

    always #5 clk = ~clk;

    rebel_logic_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_acc(in_acc), .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_ones(out_ones)
    );

    rebel_logic_pipe #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(w5_in_valid), .in_ready(w5_in_ready), .in_op(w5_in_op),
        .in_acc(w5_in_acc), .in_a(w5_in_a), .in_b(w5_in_b), .out_valid(w5_out_valid),
        .out_ready(w5_out_ready), .out_result(w5_out_result), .out_zero(w5_out_zero),
        .out_ones(w5_out_ones)
    );

    function automatic logic [15:0] mop(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a ^ b);
            3'd4: return ~(a & b);
            3'd5: return ~(a | b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    task automatic chk(input string n, input logic [63:0] g, input logic [63:0] e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", n, g, e);
        end
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic tick(output logic f);
        logic [15:0] e;
        #1;
        if (held_v) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_result", out_result, held_r);
        end
        if (out_valid && out_ready) begin
            got_q.push_back(out_result);
            cyc_q.push_back(ncyc);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty got=%0h exp=none", out_result);
            end else begin
                e = exp_q.pop_front();
                chk("sb_result", out_result, e);
                chk("sb_zero", out_zero, e == 16'h0);
                chk("sb_ones", out_ones, $countones(e));
            end
        end
        held_v = out_valid && !out_ready;
        held_r = out_result;
        f = in_valid && in_ready;
        if (f) begin
            e = mop(in_op, in_a, in_acc ? macc : in_b);
            macc = e;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    initial begin
        logic f;
        int   k;
        logic [15:0] acc_exp[3];
        tv[0] = '{3'd3, 16'h1559, 16'h1551, 16'hFFF7, 1'b0, 5'd15};
        tv[1] = '{3'd2, 16'h00FF, 16'h00FF, 16'h0000, 1'b1, 5'd0};
        tv[2] = '{3'd0, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 5'd4};
        tv[3] = '{3'd1, 16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0, 5'd12};
        tv[4] = '{3'd4, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 5'd0};
        tv[5] = '{3'd5, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 5'd16};
        tv[6] = '{3'd6, 16'h1234, 16'hFFFF, 16'hEDCB, 1'b0, 5'd11};
        tv[7] = '{3'd7, 16'h8001, 16'h1234, 16'h8001, 1'b0, 5'd2};
        acc_exp = '{16'h0F0F, 16'h0FF0, 16'h0FF0};

        rst = 1'b1;
        in_valid = 0; in_op = 0; in_acc = 0; in_a = 0; in_b = 0; out_ready = 0;
        w5_in_valid = 0; w5_in_op = 0; w5_in_acc = 0; w5_in_a = 0; w5_in_b = 0; w5_out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_result", out_result, 0);
        chk("rst_zero", out_zero, 0);
        chk("rst_ones", out_ones, 0);
        chk("rst5_valid", w5_out_valid, 0);
        rst = 1'b0;

        // Table vectors: single transactions, exact 2-cycle latency
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_op = tv[i].op; in_a = tv[i].a; in_b = tv[i].b; in_acc = 0;
            tick(f);
            chk("tbl_fire", f, 1);
            in_valid = 0;
            chk("tbl_early", out_valid, 0);
            tick(f);
            chk("tbl_valid", out_valid, 1);
            chk("tbl_result", out_result, tv[i].r);
            chk("tbl_zero", out_zero, tv[i].z);
            chk("tbl_ones", out_ones, tv[i].n);
            tick(f);
        end

        // Back-to-back accumulate chain
        got_q.delete(); cyc_q.delete();
        in_valid = 1; in_acc = 0; in_op = 3'd7; in_a = 16'h0F0F; in_b = 16'h5555;
        tick(f);
        in_acc = 1; in_op = 3'd2; in_a = 16'h00FF;
        tick(f);
        in_op = 3'd3; in_a = 16'hFFFF;
        tick(f);
        in_valid = 0; in_acc = 0;
        repeat (4) tick(f);
        chk("acc_count", got_q.size(), 3);
        for (int i = 0; i < got_q.size() && i < 3; i++) chk("acc_result", got_q[i], acc_exp[i]);
        if (got_q.size() == 3) chk("acc_consec", cyc_q[2] - cyc_q[0], 2);

        // Backpressure: 5 stalled cycles while streaming 4 ops
        got_q.delete(); cyc_q.delete();
        out_ready = 0; k = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (k < 4); in_op = 3'd7; in_acc = 0; in_a = 16'(k + 1);
            tick(f);
            if (f) k++;
        end
        chk("bp_accepted", k, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_hold", out_result, 16'h0001);
        out_ready = 1;
        for (int c = 0; c < 20 && got_q.size() < 4; c++) begin
            in_valid = (k < 4); in_a = 16'(k + 1);
            tick(f);
            if (f) k++;
        end
        in_valid = 0;
        chk("bp_count", got_q.size(), 4);
        for (int i = 0; i < got_q.size() && i < 4; i++) chk("bp_order", got_q[i], 16'(i + 1));

        // Reset while both stages are full and stalled
        out_ready = 0;
        in_valid = 1; in_op = 3'd7; in_acc = 0; in_a = 16'hAAAA;
        repeat (3) tick(f);
        in_valid = 0;
        chk("rs_full", out_valid, 1);
        rst = 1;
        in_valid = 1; in_op = 3'd0; in_acc = 1; in_a = 16'hFFFF;
        #1;
        chk("rs_valid", out_valid, 0);
        chk("rs_result", out_result, 0);
        chk("rs_ones", out_ones, 0);
        chk("rs_zero", out_zero, 0);
        @(posedge clk);
        #1;
        rst = 0; in_valid = 0;
        exp_q.delete(); macc = '0; held_v = 0;
        out_ready = 1;
        tick(f);
        tick(f);
        chk("rs_ignored", out_valid, 0);
        in_valid = 1; in_op = 3'd0; in_acc = 1; in_a = 16'hFFFF;
        tick(f);
        in_valid = 0; in_acc = 0;
        tick(f);
        chk("rs_acc_valid", out_valid, 1);
        chk("rs_acc_result", out_result, 16'h0000);
        chk("rs_acc_zero", out_zero, 1);
        tick(f);

        // WIDTH=5 instance
        w5_in_valid = 1; w5_in_op = 3'd4; w5_in_a = 5'b10110; w5_in_b = 5'b11100;
        @(posedge clk); #1;
        w5_in_op = 3'd6; w5_in_a = 5'b00000;
        @(posedge clk); #1;
        w5_in_valid = 0;
        chk("w5_valid", w5_out_valid, 1);
        chk("w5_nand", w5_out_result, 5'b01011);
        chk("w5_nand_ones", w5_out_ones, 3);
        @(posedge clk); #1;
        chk("w5_nota", w5_out_result, 5'b11111);
        chk("w5_nota_ones", w5_out_ones, 5);
        chk("w5_nota_zero", w5_out_zero, 0);

        // Random traffic against the queue model
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_op = 3'($urandom_range(0, 7));
            in_acc = 1'($urandom_range(0, 1));
            in_b = 16'($urandom);
            in_a = ($urandom_range(0, 7) == 0) ? in_b : 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick(f);
        end
        in_valid = 0; out_ready = 1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) tick(f);
        chk("drain_empty", exp_q.size(), 0);
        tick(f);
        chk("drain_idle", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
